full_st0_mode_sched: RTL and testbench
======================================

// Module: full_st0_mode_sched
// PURPOSE
//  Scheduler for the stage-0 data FIFO controller. Decides per pass whether
//  the shared tap/data pipeline runs a forward pass or an error-update pass,
//  and drives the error_update_* / state_length controls into that controller.
//  Tracks forward passes still awaiting error back-propagation, flushes the
//  pipeline on every mode switch, and bounds forward runs so errors never starve.
// PARAMETERS
//  CREDIT_W   3   width of outstanding-forward-pass counter
//  MAX_OUT    7   max forward passes outstanding without an error pass (<=2^CREDIT_W-1)
//  DRAIN_CYC  12  pipeline flush cycles on a mode switch (matches 12-deep valid pipe)
//  FAIR_MAX   4   max consecutive forward passes while an error is pending
// PORTS
//  clk                  in   1         clock
//  reset                in   1         async reset, active-low (0 = reset)
//  enable               in   1         permit new passes; in-flight pass always completes
//  fifo_has_data        in   1         forward data ready in stage-0 FIFO
//  err_valid            in   1         downstream error vector available
//  state_finish         in   1         1-cycle pulse: current pass complete
//  err_rdy              out  1         1-cycle pulse: error vector consumed
//  error_update_mode    out  1         high in ERR state
//  error_update_latch   out  1         high from ERR entry until next FWD entry
//  error_update_first   out  1         1-cycle pulse, first cycle of each ERR pass
//  error_finish_tap     out  1         1-cycle pulse, cycle after ERR-pass state_finish
//  error_tap_update_out out  1         high during an ERR pass that brings outstanding to 0
//  state_length         out  1         1 in ERR (two sub-states per pass), 0 otherwise
//  outstanding          out  CREDIT_W  forward passes awaiting error
//  busy                 out  1         state != IDLE
// BEHAVIOUR
//  Reset: every output 0, state IDLE, outstanding=0, fwd_run=0, drain_cnt=0. All outputs registered.
//  Mid-pass reset aborts immediately; no partial credit update.
//  States: IDLE, FWD, ERR, DRAIN (target field holds FWD or ERR).
//  err_win = err_valid & outstanding!=0 & (~fwd_ok | fwd_run==FAIR_MAX | current mode ERR).
//  fwd_ok  = fifo_has_data & outstanding<MAX_OUT.
//  IDLE: enable & err_win -> ERR; else enable & fwd_ok -> FWD; 1-cycle decision latency, no drain.
//  FWD, on state_finish: outstanding+=1; fwd_run+=1 if err_valid else 0.
//    next (evaluated on post-increment values): ~enable -> IDLE;
//    err_win -> DRAIN(ERR); fwd_ok -> FWD (back-to-back, no drain); else IDLE.
//  ERR, on state_finish: outstanding-=1; fwd_run=0; next cycle err_rdy=1 and error_finish_tap=1.
//    next (evaluated on post-decrement values): ~enable -> IDLE;
//    err_valid & outstanding!=0 -> ERR (re-entry; first pulses again);
//    fwd_ok -> DRAIN(FWD); else IDLE.
//  DRAIN: drain_cnt counts 0..DRAIN_CYC-1, then -> target. error_update_latch holds its value.
//    enable low in DRAIN: finish count, then IDLE.
//  error_update_first asserts on the first ERR cycle, including ERR-to-ERR re-entry.
//  error_tap_update_out is set on ERR entry when outstanding==1 and cleared on ERR exit.
//  outstanding never wraps: FWD entry requires <MAX_OUT, ERR entry requires !=0.
//    Increment and decrement cannot coincide. Bench asserts both.
//  state_finish outside FWD/ERR is ignored, and no counter changes.
//  Changes in err_valid or fifo_has_data during a pass are sampled only at a state_finish or in IDLE.
// TESTING
//  1 reset low mid-FWD -> all outputs 0 next edge, IDLE, outstanding 0.
//  2 fifo_has_data=1, err_valid=0, 8 state_finish pulses -> outstanding reaches 7, then IDLE;
//    no 8th FWD entry.
//  3 outstanding=2, err_valid=1, fifo empty -> DRAIN 12 cycles, ERR with first pulse;
//    2 passes; tap_update_out only in 2nd; finish_tap/err_rdy each 2x; outstanding 0.
//  4 both sources ready continuously -> exactly 4 FWD passes, then DRAIN(ERR),
//    1 ERR pass, then DRAIN(FWD).
//  5 enable dropped in DRAIN -> 12 drain cycles complete, then IDLE; latch unchanged.
//  6 state_finish pulsed in IDLE/DRAIN -> outstanding, fwd_run and state unchanged.

Source files
------------

// File: rtl/full_st0_mode_sched_if.sv
// Control/status bundle between the stage-0 mode scheduler (master) and the
// stage-0 data FIFO controller plus error source (slave).
interface full_st0_mode_sched_if #(
  parameter int unsigned CREDIT_W = 3
);
  logic                enable;
  logic                fifo_has_data;
  logic                err_valid;
  logic                state_finish;
  logic                err_rdy;
  logic                error_update_mode;
  logic                error_update_latch;
  logic                error_update_first;
  logic                error_finish_tap;
  logic                error_tap_update_out;
  logic                state_length;
  logic [CREDIT_W-1:0] outstanding;
  logic                busy;

  modport master (
    input  enable, fifo_has_data, err_valid, state_finish,
    output err_rdy, error_update_mode, error_update_latch, error_update_first,
           error_finish_tap, error_tap_update_out, state_length, outstanding, busy
  );

  modport slave (
    output enable, fifo_has_data, err_valid, state_finish,
    input  err_rdy, error_update_mode, error_update_latch, error_update_first,
           error_finish_tap, error_tap_update_out, state_length, outstanding, busy
  );
endinterface

// File: rtl/full_st0_mode_sched.sv
// Stage-0 pass scheduler: picks forward vs error-update passes, flushes the
// shared pipeline on mode switches and keeps forward runs from starving errors.
module full_st0_mode_sched #(
  parameter int unsigned CREDIT_W  = 3,
  parameter int unsigned MAX_OUT   = 7,
  parameter int unsigned DRAIN_CYC = 12,
  parameter int unsigned FAIR_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  full_st0_mode_sched_if.master sif
);
  localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int unsigned RUN_W   = $clog2(FAIR_MAX + 1);

  localparam logic [CREDIT_W-1:0] MAX_OUT_C  = CREDIT_W'(MAX_OUT);
  localparam logic [CREDIT_W-1:0] ONE_C      = CREDIT_W'(1);
  localparam logic [RUN_W-1:0]    FAIR_MAX_C = RUN_W'(FAIR_MAX);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_ERR, S_DRAIN} state_e;

  state_e              state_q, state_d;
  state_e              target_q, target_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [CREDIT_W-1:0] outstanding_q, outstanding_d;
  logic [RUN_W-1:0]    fwd_run_q, fwd_run_d;
  logic                err_rdy_q, err_rdy_d;
  logic                mode_q, mode_d;
  logic                latch_q, latch_d;
  logic                first_q, first_d;
  logic                finish_tap_q, finish_tap_d;
  logic                tap_out_q, tap_out_d;
  logic                length_q, length_d;
  logic                busy_q, busy_d;

  logic fwd_ok;
  logic err_win;
  logic err_entry;
  logic err_done;

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    drain_cnt_d   = drain_cnt_q;
    outstanding_d = outstanding_q;
    fwd_run_d     = fwd_run_q;
    err_entry     = 1'b0;
    err_done      = 1'b0;

    // Credit/run updates first so the routing below sees post-update values.
    case (state_q)
      S_FWD: if (sif.state_finish) begin
        outstanding_d = outstanding_q + 1'b1;
        if (!sif.err_valid)
          fwd_run_d = '0;
        else if (fwd_run_q != FAIR_MAX_C)
          fwd_run_d = fwd_run_q + 1'b1;
      end
      S_ERR: if (sif.state_finish) begin
        outstanding_d = outstanding_q - 1'b1;
        fwd_run_d     = '0;
        err_done      = 1'b1;
      end
      default: ;
    endcase

    fwd_ok  = sif.fifo_has_data && (outstanding_d < MAX_OUT_C);
    err_win = sif.err_valid && (outstanding_d != '0) &&
              (!fwd_ok || (fwd_run_d == FAIR_MAX_C) || (state_q == S_ERR));

    case (state_q)
      S_IDLE: begin
        if (sif.enable && err_win) begin
          state_d   = S_ERR;
          err_entry = 1'b1;
        end else if (sif.enable && fwd_ok) begin
          state_d = S_FWD;
        end
      end
      S_FWD: if (sif.state_finish) begin
        if (!sif.enable) begin
          state_d = S_IDLE;
        end else if (err_win) begin
          state_d  = S_DRAIN;
          target_d = S_ERR;
        end else if (fwd_ok) begin
          state_d = S_FWD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR: if (sif.state_finish) begin
        if (!sif.enable) begin
          state_d = S_IDLE;
        end else if (err_win) begin
          state_d   = S_ERR;
          err_entry = 1'b1;
        end else if (fwd_ok) begin
          state_d  = S_DRAIN;
          target_d = S_FWD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
          if (sif.enable) begin
            state_d   = target_q;
            err_entry = (target_q == S_ERR);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    err_rdy_d    = err_done;
    finish_tap_d = err_done;
    first_d      = err_entry;
    mode_d       = (state_d == S_ERR);
    length_d     = (state_d == S_ERR);
    busy_d       = (state_d != S_IDLE);

    if (err_entry)
      latch_d = 1'b1;
    else if (state_d == S_FWD)
      latch_d = 1'b0;
    else
      latch_d = latch_q;

    if (err_entry)
      tap_out_d = (outstanding_d == ONE_C);
    else if (state_d == S_ERR)
      tap_out_d = tap_out_q;
    else
      tap_out_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      target_q      <= S_IDLE;
      drain_cnt_q   <= '0;
      outstanding_q <= '0;
      fwd_run_q     <= '0;
      err_rdy_q     <= 1'b0;
      mode_q        <= 1'b0;
      latch_q       <= 1'b0;
      first_q       <= 1'b0;
      finish_tap_q  <= 1'b0;
      tap_out_q     <= 1'b0;
      length_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      drain_cnt_q   <= drain_cnt_d;
      outstanding_q <= outstanding_d;
      fwd_run_q     <= fwd_run_d;
      err_rdy_q     <= err_rdy_d;
      mode_q        <= mode_d;
      latch_q       <= latch_d;
      first_q       <= first_d;
      finish_tap_q  <= finish_tap_d;
      tap_out_q     <= tap_out_d;
      length_q      <= length_d;
      busy_q        <= busy_d;
    end
  end

  assign sif.err_rdy              = err_rdy_q;
  assign sif.error_update_mode    = mode_q;
  assign sif.error_update_latch   = latch_q;
  assign sif.error_update_first   = first_q;
  assign sif.error_finish_tap     = finish_tap_q;
  assign sif.error_tap_update_out = tap_out_q;
  assign sif.state_length         = length_q;
  assign sif.outstanding          = outstanding_q;
  assign sif.busy                 = busy_q;
endmodule

// File: tb/tb_full_st0_mode_sched.sv
// Bench for full_st0_mode_sched: table vectors, directed multi-cycle scenarios
// and randomized traffic against a pass-level reference model.
module tb_full_st0_mode_sched;
  localparam int CREDIT_W  = 3;
  localparam int MAX_OUT   = 7;
  localparam int DRAIN_CYC = 12;
  localparam int FAIR_MAX  = 4;
  localparam int VW        = 8 + CREDIT_W;

  logic clk = 1'b0;
  logic reset;

  full_st0_mode_sched_if #(.CREDIT_W(CREDIT_W)) sif ();

  full_st0_mode_sched #(
    .CREDIT_W (CREDIT_W),
    .MAX_OUT  (MAX_OUT),
    .DRAIN_CYC(DRAIN_CYC),
    .FAIR_MAX (FAIR_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sif  (sif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the scheduler is doing, in pass-level terms.
  typedef enum {M_IDLE, M_FWD, M_ERR, M_DRAIN} mphase_e;
  mphase_e m_phase, m_goal;
  int m_left, m_out, m_run;
  bit m_latch, m_tap, m_first, m_done;

  int cnt_rdy, cnt_ftap, last_out;
  bit last_valid;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {sif.err_rdy, sif.error_update_mode, sif.error_update_latch,
            sif.error_update_first, sif.error_finish_tap, sif.error_tap_update_out,
            sif.state_length, sif.busy, sif.outstanding};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_done, m_phase == M_ERR, m_latch, m_first, m_done, m_tap,
            m_phase == M_ERR, m_phase != M_IDLE, CREDIT_W'(m_out)};
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_goal = M_IDLE; m_left = 0; m_out = 0; m_run = 0;
    m_latch = 0; m_tap = 0; m_first = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit en  = sif.enable;
    bit fd  = sif.fifo_has_data;
    bit ev  = sif.err_valid;
    bit fin = sif.state_finish;
    bit pass_end = ((m_phase == M_FWD) || (m_phase == M_ERR)) && fin;
    bit data_go, err_go, enter_err;
    mphase_e was = m_phase;
    m_first = 0; m_done = 0; enter_err = 0;
    if (was == M_FWD && fin) begin
      m_out++;
      m_run = ev ? ((m_run + 1 > FAIR_MAX) ? FAIR_MAX : m_run + 1) : 0;
    end
    if (was == M_ERR && fin) begin
      m_out--; m_run = 0; m_done = 1;
    end
    data_go = fd && (m_out < MAX_OUT);
    err_go  = ev && (m_out > 0) && (!data_go || m_run == FAIR_MAX || was == M_ERR);
    if (was == M_DRAIN) begin
      m_left--;
      if (m_left == 0) begin
        m_phase = en ? m_goal : M_IDLE;
        enter_err = en && (m_goal == M_ERR);
      end
    end else if (was == M_IDLE || pass_end) begin
      if (!en) m_phase = M_IDLE;
      else if (err_go) begin
        if (was == M_FWD) begin m_phase = M_DRAIN; m_goal = M_ERR; m_left = DRAIN_CYC; end
        else begin m_phase = M_ERR; enter_err = 1; end
      end else if (data_go) begin
        if (was == M_ERR) begin m_phase = M_DRAIN; m_goal = M_FWD; m_left = DRAIN_CYC; end
        else m_phase = M_FWD;
      end else m_phase = M_IDLE;
    end
    m_first = enter_err;
    if (enter_err) begin m_latch = 1; m_tap = (m_out == 1); end
    else begin
      if (m_phase == M_FWD) m_latch = 0;
      if (m_phase != M_ERR) m_tap = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL outputs: got %h expected %h at %0t", dut_vec(), exp_vec(), $time);
    end
    cnt_rdy  += int'(sif.err_rdy);
    cnt_ftap += int'(sif.error_finish_tap);
    if (reset && last_valid) begin
      int d = int'(sif.outstanding) - last_out;
      chk("credit_step", int'((d >= -1) && (d <= 1) && (sif.outstanding <= MAX_OUT)), 1);
    end
    last_out   = int'(sif.outstanding);
    last_valid = reset;
  endtask

  typedef struct {
    logic en, fd, ev, fin;
    logic exp_busy, exp_mode;
    int   exp_out;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{1, 1, 0, 0, 1, 0, 0};
    for (int i = 1; i <= 6; i++) tbl[i] = '{1, 1, 0, 1, 1, 0, i};
    tbl[7] = '{1, 1, 0, 1, 0, 0, 7};
    tbl[8] = '{1, 1, 0, 1, 0, 0, 7};
    tbl[9] = '{1, 1, 0, 0, 0, 0, 7};

    sif.enable = 0; sif.fifo_has_data = 0; sif.err_valid = 0; sif.state_finish = 0;
    reset = 0; model_reset(); last_valid = 0; cnt_rdy = 0; cnt_ftap = 0; last_out = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'(dut_vec()), 0);

    // Reset dropped in the middle of a forward pass.
    reset = 1; sif.enable = 1; sif.fifo_has_data = 1;
    step(); step(); step();
    reset = 0; #1;
    chk("mid_fwd_reset_async", int'(dut_vec()), 0);
    step();
    chk("mid_fwd_reset_edge", int'(dut_vec()), 0);
    reset = 1;

    // Forward credits saturate at MAX_OUT; state_finish in IDLE is ignored.
    for (int i = 0; i < 10; i++) begin
      sif.enable = tbl[i].en; sif.fifo_has_data = tbl[i].fd;
      sif.err_valid = tbl[i].ev; sif.state_finish = tbl[i].fin;
      step();
      chk($sformatf("tbl%0d", i),
          int'({sif.busy, sif.error_update_mode, sif.error_update_latch, sif.state_length}),
          int'({tbl[i].exp_busy, tbl[i].exp_mode, 1'b0, tbl[i].exp_mode}));
      chk($sformatf("tbl%0d_out", i), int'(sif.outstanding), tbl[i].exp_out);
    end
    sif.state_finish = 0;

    // Two outstanding passes drained by back-to-back error passes.
    reset = 0; step(); reset = 1;
    sif.enable = 1; sif.fifo_has_data = 1; sif.err_valid = 0;
    step();
    sif.state_finish = 1; step();
    sif.fifo_has_data = 0; sif.err_valid = 1; step();
    sif.state_finish = 0;
    n = 0;
    for (int i = 0; i < 40 && !sif.error_update_first; i++) begin step(); n++; end
    chk("t3_drain_len", n, DRAIN_CYC);
    chk("t3_out_at_err", int'(sif.outstanding), 2);
    chk("t3_tap_pass1", int'(sif.error_tap_update_out), 0);
    cnt_rdy = 0; cnt_ftap = 0;
    step(); step();
    chk("t3_tap_pass1_late", int'(sif.error_tap_update_out), 0);
    sif.state_finish = 1; step();
    chk("t3_reentry_first", int'({sif.error_update_first, sif.err_rdy, sif.error_tap_update_out}), 7);
    chk("t3_out_mid", int'(sif.outstanding), 1);
    sif.state_finish = 0; step();
    sif.state_finish = 1; step();
    sif.state_finish = 0; step(); step();
    chk("t3_err_rdy_count", cnt_rdy, 2);
    chk("t3_finish_tap_count", cnt_ftap, 2);
    chk("t3_final", int'({sif.busy, sif.error_tap_update_out, sif.outstanding}), 0);

    // Both sources ready: fairness forces an error pass after FAIR_MAX forwards.
    reset = 0; step(); reset = 1;
    sif.enable = 1; sif.fifo_has_data = 1; sif.err_valid = 1;
    step();
    for (int k = 0; k < FAIR_MAX; k++) begin
      sif.state_finish = 0; step();
      sif.state_finish = 1; step();
    end
    chk("t4_fwd_passes", int'(sif.outstanding), FAIR_MAX);
    chk("t4_not_err_yet", int'(sif.error_update_mode), 0);
    n = 0;
    for (int i = 0; i < 40 && !sif.error_update_first; i++) begin
      sif.state_finish = (i == 5); step(); n++;
    end
    sif.state_finish = 0;
    chk("t4_drain_len", n, DRAIN_CYC);
    chk("t4_out_after_stray_finish", int'(sif.outstanding), FAIR_MAX);
    step();
    sif.err_valid = 0; sif.state_finish = 1; step();
    sif.state_finish = 0;
    chk("t4_to_drain_fwd", int'({sif.err_rdy, sif.error_update_mode, sif.busy, sif.error_update_latch}), 4'b1011);

    // Enable dropped mid-drain: drain completes, then IDLE with latch held.
    n = 0;
    for (int i = 0; i < 40 && sif.busy; i++) begin
      n++;
      if (i == 3) sif.enable = 0;
      step();
    end
    chk("t5_drain_len", n, DRAIN_CYC);
    chk("t5_idle_latch", int'({sif.busy, sif.error_update_latch, sif.outstanding}), {1'b0, 1'b1, 3'd3});
    step();
    chk("t5_stays_idle", int'(sif.busy), 0);

    // Randomized traffic against the model.
    reset = 0; step(); reset = 1;
    for (int c = 0; c < 4000; c++) begin
      sif.enable        = 1'($urandom_range(0, 15) != 0);
      sif.fifo_has_data = 1'($urandom_range(0, 2) != 0);
      sif.err_valid     = 1'($urandom_range(0, 1));
      sif.state_finish  = 1'($urandom_range(0, 3) == 0);
      reset             = 1'($urandom_range(0, 599) != 0);
      step();
    end
    reset = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
